// File: rtl/morse_output_module.sv
// morse_output_module: Morse mark/space waveform generator timed by an external tick enable; optional MORSE_OUTPUT_REPEAT_EN adds a repeat input that loops the character.
module morse_output_module #(
    parameter int MAX_LEN          = 5,
    parameter int DOT_UNITS        = 1,
    parameter int DASH_UNITS       = 3,
    parameter int GAP_UNITS        = 1,
    parameter int LETTER_GAP_UNITS = 3,
    parameter int CNT_W            = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               tick,
    input  logic               load,
    input  logic [MAX_LEN-1:0] symbols,
    input  logic [2:0]         length,
`ifdef MORSE_OUTPUT_REPEAT_EN
    input  logic               repeat_en,
`endif
    output logic               signal_out,
    output logic               busy,
    output logic               done
);
    typedef enum logic [1:0] {IDLE, MARK, SPACE, LETTER_GAP} state_t;
    localparam logic [CNT_W-1:0] DOT_L  = CNT_W'(DOT_UNITS - 1);
    localparam logic [CNT_W-1:0] DASH_L = CNT_W'(DASH_UNITS - 1);
    localparam logic [CNT_W-1:0] GAP_L  = CNT_W'(GAP_UNITS - 1);
    localparam logic [CNT_W-1:0] LG_L   = CNT_W'(LETTER_GAP_UNITS - 1);
    state_t state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MAX_LEN-1:0] shift_q, shift_d;
    logic [2:0] rem_q, rem_d;
    logic sig_q, sig_d, busy_q, busy_d, done_q, done_d;
`ifdef MORSE_OUTPUT_REPEAT_EN
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [2:0] len_q, len_d;
`endif
    logic [2:0] len_c;
    logic [CNT_W-1:0] mark_last;
    assign len_c     = (length > 3'(MAX_LEN)) ? 3'(MAX_LEN) : length;
    assign mark_last = shift_q[0] ? DASH_L : DOT_L;
    // state and registered outputs, all cleared by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            rem_q   <= '0;
            sig_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef MORSE_OUTPUT_REPEAT_EN
            pat_q   <= '0;
            len_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            rem_q   <= rem_d;
            sig_q   <= sig_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef MORSE_OUTPUT_REPEAT_EN
            pat_q   <= pat_d;
            len_q   <= len_d;
`endif
        end
    end
    // next state: each mark or gap ends on the Nth tick seen in that state
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        rem_d   = rem_q;
`ifdef MORSE_OUTPUT_REPEAT_EN
        pat_d   = pat_q;
        len_d   = len_q;
`endif
        case (state_q)
            IDLE: if (load && len_c != 3'd0) begin
                state_d = MARK;
                cnt_d   = '0;
                shift_d = symbols;
                rem_d   = len_c;
`ifdef MORSE_OUTPUT_REPEAT_EN
                pat_d   = symbols;
                len_d   = len_c;
`endif
            end
            MARK: if (tick) begin
                if (cnt_q == mark_last) begin
                    cnt_d   = '0;
                    rem_d   = rem_q - 3'd1;
                    state_d = (rem_q > 3'd1) ? SPACE : LETTER_GAP;
                end else cnt_d = cnt_q + 1'b1;
            end
            SPACE: if (tick) begin
                if (cnt_q == GAP_L) begin
                    cnt_d   = '0;
                    shift_d = shift_q >> 1;
                    state_d = MARK;
                end else cnt_d = cnt_q + 1'b1;
            end
            LETTER_GAP: if (tick) begin
                if (cnt_q == LG_L) begin
                    cnt_d   = '0;
                    state_d = IDLE;
`ifdef MORSE_OUTPUT_REPEAT_EN
                    if (repeat_en) begin
                        state_d = MARK;
                        shift_d = pat_q;
                        rem_d   = len_q;
                    end
`endif
                end else cnt_d = cnt_q + 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end
    // outputs derived from the upcoming state so they appear registered
    always_comb begin
        sig_d  = state_d == MARK;
        busy_d = state_d != IDLE;
        done_d = (state_q == LETTER_GAP && state_d == IDLE) || (state_q == IDLE && load && len_c == 3'd0);
    end
    assign signal_out = sig_q;
    assign busy       = busy_q;
    assign done       = done_q;
endmodule

// File: tb/tb_morse_output_module.sv
// tb_morse_output_module: scoreboard bench comparing per-cycle {signal_out,busy,done} against a spec-derived expectation queue.
module tb_morse_output_module;
    logic clock = 1'b0;
    logic reset, tick, load;
    logic [4:0] symbols;
    logic [2:0] length;
    logic signal_out, busy, done;
    logic [2:0] q[$];
    int checks = 0;
    int failures = 0;
    int cyc = 0;
    string tname = "";

    morse_output_module dut (
        .clock(clock), .reset(reset), .tick(tick), .load(load),
        .symbols(symbols), .length(length),
        .signal_out(signal_out), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        logic [2:0] e;
        @(posedge clock);
        #1;
        cyc++;
        if (q.size() > 0) begin
            e = q.pop_front();
            check($sformatf("%s_c%0d", tname, cyc), {29'd0, signal_out, busy, done}, {29'd0, e});
        end
    endtask

    task automatic push_n(input logic [2:0] v, input int n);
        for (int i = 0; i < n; i++) q.push_back(v);
    endtask

    task automatic push_char(input logic [4:0] sym, input int len);
        int n;
        n = (len > 5) ? 5 : len;
        if (n == 0) q.push_back(3'b001);
        else begin
            for (int i = 0; i < n; i++) begin
                push_n(3'b110, sym[i] ? 3 : 1);
                if (i < n - 1) push_n(3'b010, 1);
            end
            push_n(3'b010, 3);
            q.push_back(3'b001);
        end
    endtask

    task automatic send(input logic [4:0] sym, input logic [2:0] len, input int per, input int ld_at);
        int k;
        symbols = sym;
        length  = len;
        load    = 1'b1;
        tick    = 1'b1;
        cyc     = 0;
        step();
        load = 1'b0;
        k = 1;
        while (q.size() > 0) begin
            tick = (k % per) == per - 1;
            if (k == ld_at) begin
                load    = 1'b1;
                symbols = 5'b11111;
                length  = 3'd5;
            end else load = 1'b0;
            step();
            k++;
        end
        load = 1'b0;
        tick = 1'b1;
    endtask

    initial begin
        reset = 1'b1; tick = 1'b0; load = 1'b0; symbols = '0; length = '0;
        repeat (2) @(posedge clock);
        #1;
        check("reset_out", {29'd0, signal_out, busy, done}, 32'd0);
        reset = 1'b0;
        tname = "S";
        push_char(5'b00000, 3);
        send(5'b00000, 3'd3, 1, 0);
        tname = "A_in_done_cycle";
        push_char(5'b00010, 2);
        send(5'b00010, 3'd2, 1, 0);
        tname = "midload";
        push_char(5'b00000, 3);
        send(5'b00000, 3'd3, 1, 2);
        tname = "E_slow";
        push_n(3'b110, 3);
        push_n(3'b010, 12);
        push_n(3'b001, 1);
        push_n(3'b000, 1);
        send(5'b00000, 3'd1, 4, 0);
        tname = "len0";
        push_n(3'b001, 1);
        push_n(3'b000, 1);
        send(5'b00000, 3'd0, 1, 0);
        tname = "len7";
        push_char(5'b10101, 7);
        send(5'b10101, 3'd7, 1, 0);
        symbols = 5'b00001; length = 3'd1; load = 1'b1; tick = 1'b1;
        step();
        load = 1'b0;
        step();
        check("dash_mark", {31'd0, signal_out}, 32'd1);
        reset = 1'b1;
        step();
        check("reset_mid_dash", {29'd0, signal_out, busy, done}, 32'd0);
        reset = 1'b0;
        tname = "A_after_reset";
        push_char(5'b00010, 2);
        push_n(3'b000, 1);
        send(5'b00010, 3'd2, 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
